sdram_arbiter: RTL

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// Three-port arbiter in front of sdramburst: video, mmu and aux share one SDRAM
// burst engine. Fixed priority with a starvation guard so video cannot lock out the others.
module sdram_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 16,
  parameter int BLW          = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           req,
  input  logic [2:0]           rw,
  input  logic [3*AW-1:0]      address,
  input  logic [3*DW-1:0]      write_data,
  input  logic [3*BLW-1:0]     burst_len,
  output logic [2:0]           grant,
  output logic [2:0]           bursting,
  output logic [DW-1:0]        read_data,
  output logic [AW-1:0]        sd_address,
  output logic                 sd_rw_req,
  output logic                 sd_rw,
  output logic [DW-1:0]        sd_write_data,
  output logic [BLW-1:0]       sd_burst_len,
  input  logic [DW-1:0]        sd_read_data,
  input  logic                 sd_bursting
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, BURST, RELEASE} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      owner_reg, owner_next;
  logic [2:0]      grant_reg, grant_next;
  logic            sd_rw_req_reg, sd_rw_req_next;
  logic [SW-1:0]   starve_reg, starve_next;

  logic            starve_hit;
  logic [1:0]      win_idx;
  logic            owner_req;

  always_comb begin
    unique case (owner_reg)
      2'd0:    owner_req = req[0];
      2'd1:    owner_req = req[1];
      default: owner_req = req[2];
    endcase
  end

  // Once video has been granted STARVE_LIMIT times over a waiting port, the waiter wins.
  always_comb begin
    starve_hit = (starve_reg == STARVE_MAX) && (req[1] || req[2]);
    if (starve_hit)  win_idx = req[1] ? 2'd1 : 2'd2;
    else if (req[0]) win_idx = 2'd0;
    else if (req[1]) win_idx = 2'd1;
    else             win_idx = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      owner_reg     <= 2'd0;
      grant_reg     <= 3'b000;
      sd_rw_req_reg <= 1'b0;
      starve_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      grant_reg     <= grant_next;
      sd_rw_req_reg <= sd_rw_req_next;
      starve_reg    <= starve_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (|req) state_next = ISSUE;
      ISSUE: begin
        if (sd_bursting)     state_next = BURST;
        else if (!owner_req) state_next = IDLE;
      end
      BURST:   if (!sd_bursting) state_next = RELEASE;
      RELEASE: state_next = IDLE;
    endcase
  end

  always_comb begin
    owner_next     = owner_reg;
    grant_next     = grant_reg;
    sd_rw_req_next = sd_rw_req_reg;
    starve_next    = starve_reg;
    unique case (state_reg)
      IDLE: begin
        if (|req) begin
          owner_next     = win_idx;
          grant_next     = 3'b001 << win_idx;
          sd_rw_req_next = 1'b1;
          if (win_idx != 2'd0)
            starve_next = '0;
          else if ((req[1] || req[2]) && (starve_reg != STARVE_MAX))
            starve_next = starve_reg + SW'(1);
        end
      end
      ISSUE: begin
        sd_rw_req_next = owner_req;
        if (!sd_bursting && !owner_req) grant_next = 3'b000;
      end
      BURST: begin
        sd_rw_req_next = owner_req;
        if (!sd_bursting) begin
          grant_next     = 3'b000;
          sd_rw_req_next = 1'b0;
        end
      end
      RELEASE: begin
        grant_next     = 3'b000;
        sd_rw_req_next = 1'b0;
      end
    endcase
  end

  // Grant is one-hot, so an AND-OR mux selects the owner's slice and yields 0 when idle.
  logic [AW-1:0]  addr_sel [3];
  logic [DW-1:0]  wd_sel   [3];
  logic [BLW-1:0] bl_sel   [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_port
    assign addr_sel[gi] = grant_reg[gi] ? address[gi*AW +: AW]      : '0;
    assign wd_sel[gi]   = grant_reg[gi] ? write_data[gi*DW +: DW]   : '0;
    assign bl_sel[gi]   = grant_reg[gi] ? burst_len[gi*BLW +: BLW]  : '0;
  end

  assign sd_address    = addr_sel[0] | addr_sel[1] | addr_sel[2];
  assign sd_write_data = wd_sel[0]   | wd_sel[1]   | wd_sel[2];
  assign sd_burst_len  = bl_sel[0]   | bl_sel[1]   | bl_sel[2];

  // Video is read-only, so its direction bit is masked out.
  assign sd_rw     = |(rw & grant_reg & 3'b110);
  assign bursting  = grant_reg & {3{sd_bursting}};
  assign read_data = sd_read_data;
  assign grant     = grant_reg;
  assign sd_rw_req = sd_rw_req_reg;

endmodule
